// File: rtl/if_id_fifo_pkg.sv
// Shared constants and entry layout for the fetch-to-decode buffer.
package if_id_fifo_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] INST_NOP  = 32'h0000_0013;  // ADDI x0,x0,0

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } entry_t;

endpackage

// File: rtl/if_id_fifo.sv
// Fetch-to-decode buffer: small in-order queue between fetch and id,
// with valid/ready handshake, jump flush and NOP when empty.
module if_id_fifo
  import if_id_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH    = 2,
  parameter  logic [31:0] NOP_INST = INST_NOP,
  localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      inst_addr_i,
  input  logic             inst_valid_i,
  output logic             inst_ready_o,
  input  logic             hold_flag_i,
  input  logic             jump_flag_i,
  output logic [31:0]      inst_o,
  output logic [31:0]      inst_addr_o,
  output logic             inst_valid_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push;
  logic             pop;

  // Handshake flags derive only from registered count, so ready has no path from hold/jump.
  assign inst_ready_o = (count_q != CNT_FULL);
  assign inst_valid_o = (count_q != '0);
  assign count_o      = count_q;
  assign push         = inst_valid_i && inst_ready_o;
  assign pop          = inst_valid_o && !hold_flag_i;

  always_ff @(posedge clk) begin
    if (rst || jump_flag_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr_q] <= '{addr: inst_addr_i, inst: inst_i};
        wr_ptr_q      <= wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    inst_o      = NOP_INST;
    inst_addr_o = ZERO_WORD;
    if (inst_valid_o) begin
      inst_o      = mem[rd_ptr_q].inst;
      inst_addr_o = mem[rd_ptr_q].addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !jump_flag_i) begin
      assert (!(push && count_q == CNT_FULL)) else $error("if_id_fifo overflow");
      assert (!(pop && count_q == '0)) else $error("if_id_fifo underflow");
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed bench for if_id_fifo: queue-based reference model checked every cycle,
// plus hand-computed literal expectations per scenario.
module tb_if_id_fifo;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        inst_valid_i;
  logic        inst_ready_o;
  logic        hold_flag_i;
  logic        jump_flag_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic [1:0]  count_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  if_id_fifo #(.DEPTH(DEPTH), .NOP_INST(32'h0000_0013)) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .inst_valid_i (inst_valid_i),
    .inst_ready_o (inst_ready_o),
    .hold_flag_i  (hold_flag_i),
    .jump_flag_i  (jump_flag_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered list of {addr,inst} pairs.
  logic [63:0] q[$];
  bit          model_live = 0;

  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    if (rst || jump_flag_i) begin
      q.delete();
      if (rst) model_live = 1;
    end else begin
      do_push = inst_valid_i && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && !hold_flag_i;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({inst_addr_i, inst_i});
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("m_valid", 32'(inst_valid_o), 32'(q.size() != 0));
      check("m_ready", 32'(inst_ready_o), 32'(q.size() < DEPTH));
      check("m_count", 32'(count_o), 32'(q.size()));
      check("m_inst",  inst_o,      (q.size() != 0) ? q[0][31:0]  : 32'h13);
      check("m_addr",  inst_addr_o, (q.size() != 0) ? q[0][63:32] : 32'h0);
    end
  end

  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] adr,
                      input bit hold, input bit jump, input bit r);
    inst_valid_i = v;
    inst_i       = ins;
    inst_addr_i  = adr;
    hold_flag_i  = hold;
    jump_flag_i  = jump;
    rst          = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(input string name, input bit v, input logic [31:0] ins,
                             input logic [31:0] adr, input int unsigned cnt);
    check({name, "_valid"}, 32'(inst_valid_o), 32'(v));
    check({name, "_inst"},  inst_o, ins);
    check({name, "_addr"},  inst_addr_o, adr);
    check({name, "_count"}, 32'(count_o), 32'(cnt));
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // T1 reset
    expect_head("t1", 0, 32'h13, 32'h0, 0);
    check("t1_ready", 32'(inst_ready_o), 32'd1);

    // T2 streaming with one-cycle latency
    step(1, 32'h0050_0093, 32'h0, 0, 0, 0);
    expect_head("t2a", 1, 32'h0050_0093, 32'h0, 1);
    step(1, 32'h0010_8113, 32'h4, 0, 0, 0);
    expect_head("t2b", 1, 32'h0010_8113, 32'h4, 1);
    step(0, 0, 0, 0, 0, 0);
    expect_head("t2c", 0, 32'h13, 32'h0, 0);

    // T3 stall fill, hold on empty does not block push
    step(1, 32'hA, 32'h10, 1, 0, 0);
    expect_head("t3a", 1, 32'hA, 32'h10, 1);
    step(1, 32'hB, 32'h14, 1, 0, 0);
    expect_head("t3b", 1, 32'hA, 32'h10, 2);
    check("t3b_ready", 32'(inst_ready_o), 32'd0);
    step(1, 32'hC, 32'h18, 1, 0, 0);
    expect_head("t3c", 1, 32'hA, 32'h10, 2);
    step(1, 32'hC, 32'h18, 0, 0, 0);
    expect_head("t3d", 1, 32'hB, 32'h14, 1);
    check("t3d_ready", 32'(inst_ready_o), 32'd1);
    step(1, 32'hC, 32'h18, 0, 0, 0);
    expect_head("t3e", 1, 32'hC, 32'h18, 1);
    step(0, 0, 0, 0, 0, 0);
    expect_head("t3f", 0, 32'h13, 32'h0, 0);

    // T4 flush with concurrent push, under hold
    step(1, 32'h1, 32'h20, 1, 0, 0);
    step(1, 32'h2, 32'h24, 1, 0, 0);
    expect_head("t4a", 1, 32'h1, 32'h20, 2);
    step(1, 32'hD, 32'h40, 1, 1, 0);
    expect_head("t4b", 0, 32'h13, 32'h0, 0);
    step(1, 32'hE, 32'h80, 0, 0, 0);
    expect_head("t4c", 1, 32'hE, 32'h80, 1);
    step(0, 0, 0, 0, 0, 0);
    expect_head("t4d", 0, 32'h13, 32'h0, 0);

    // T5 back-to-back push/pop across pointer wrap
    for (int i = 0; i < 10; i++) begin
      step(1, 32'(i * 4), 32'(i * 4), 0, 0, 0);
      expect_head($sformatf("t5_%0d", i), 1, 32'(i * 4), 32'(i * 4), 1);
    end
    step(0, 0, 0, 0, 0, 0);
    expect_head("t5_end", 0, 32'h13, 32'h0, 0);

    // T6 reset overriding jump and push while full
    step(1, 32'h55, 32'h100, 1, 0, 0);
    step(1, 32'h66, 32'h104, 1, 0, 0);
    expect_head("t6a", 1, 32'h55, 32'h100, 2);
    step(1, 32'h77, 32'h108, 1, 1, 1);
    expect_head("t6b", 0, 32'h13, 32'h0, 0);
    check("t6b_ready", 32'(inst_ready_o), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    expect_head("t6c", 0, 32'h13, 32'h0, 0);

    step(0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
